// File: rtl/eth_tx_frame_arbiter_if.sv
// rtl/eth_tx_frame_arbiter_if.sv - requester byte streams and mini_mac TX payload stream bundle
interface eth_tx_frame_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_eof;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 mac_valid;
    logic [7:0]           mac_data;
    logic                 mac_eof;
    logic                 mac_ready;

    modport master (
        input  req_valid, req_data, req_eof, mac_ready,
        output req_ready, mac_valid, mac_data, mac_eof
    );

    modport slave (
        output req_valid, req_data, req_eof, mac_ready,
        input  req_ready, mac_valid, mac_data, mac_eof
    );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-level round-robin TX arbiter with length cap (optional ETH_TX_ARB_PRIO0_EN: requester 0 strict priority)
module eth_tx_frame_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 1500
) (
    input  logic                   clk,
    input  logic                   reset,
    eth_tx_frame_arbiter_if.master bus,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   trunc_pulse,
    output logic [15:0]            frame_cnt
);
    localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   g_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_nxt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    int                 idx_i;
    logic [15:0]        len_cnt;
    logic               v_g;
    logic               e_g;
    logic [7:0]         d_g;
    logic               force_eof;
    logic               mac_acc;

    assign v_g       = bus.req_valid[g_idx];
    assign e_g       = bus.req_eof[g_idx];
    assign d_g       = bus.req_data[int'(g_idx)*8 +: 8];
    assign force_eof = (len_cnt == LAST_IDX);
    assign mac_acc   = (state == PASS) && v_g && bus.mac_ready;
    assign busy      = (state != IDLE);
    assign rr_nxt    = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;

    // Pick the first valid requester at or above rr_ptr, wrapping; requester 0 may override.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx_i      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_i = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx_i]) begin
                pick_found = 1'b1;
                pick_idx   = idx_i[IDX_W-1:0];
            end
        end
`ifdef ETH_TX_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stream steering: only the owner sees ready, only PASS drives the MAC.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.mac_valid = 1'b0;
        bus.mac_data  = 8'h00;
        bus.mac_eof   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = PASS;
                end
            end
            PASS: begin
                bus.mac_valid        = v_g;
                bus.mac_data         = d_g;
                bus.mac_eof          = e_g | force_eof;
                bus.req_ready[g_idx] = bus.mac_ready;
                if (mac_acc) begin
                    if (e_g) begin
                        state_nxt = IDLE;
                    end else if (force_eof) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                bus.req_ready[g_idx] = 1'b1;
                if (v_g && e_g) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, round-robin pointer, length counter, frame counter and truncation pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            g_idx       <= '0;
            rr_ptr      <= '0;
            len_cnt     <= '0;
            frame_cnt   <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        g_idx   <= pick_idx;
                        len_cnt <= '0;
                    end
                end
                PASS: begin
                    if (mac_acc) begin
                        len_cnt <= len_cnt + 16'd1;
                        if (e_g || force_eof) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        if (e_g) begin
                            grant <= '0;
`ifdef ETH_TX_ARB_PRIO0_EN
                            if (g_idx != '0) rr_ptr <= rr_nxt;
`else
                            rr_ptr <= rr_nxt;
`endif
                        end else if (force_eof) begin
                            trunc_pulse <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (v_g && e_g) begin
                        grant <= '0;
`ifdef ETH_TX_ARB_PRIO0_EN
                        if (g_idx != '0) rr_ptr <= rr_nxt;
`else
                        rr_ptr <= rr_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - self-checking bench for eth_tx_frame_arbiter (NUM_REQ=4, MAX_LEN=16)
module tb_eth_tx_frame_arbiter;
    localparam int NR = 4;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] grant;
    logic          busy;
    logic          trunc_pulse;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter_if #(.NUM_REQ(NR)) bus ();

    eth_tx_frame_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant       (grant),
        .busy        (busy),
        .trunc_pulse (trunc_pulse),
        .frame_cnt   (frame_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0] rq [NR][$];
    logic [8:0] mq [NR][$];
    int         plen [NR][$];
    logic [8:0] exp_q [$];
    bit         at_start [NR];
    int         mptr, exp_frames, exp_trunc, trunc_seen, trunc_cyc;
    int         cyc, first_acc, last_acc;
    int         bubble_pct, ready_mode, ready_pct;
    bit         phase, chk_mirror;

    typedef struct {
        logic [NR-1:0] mask;
        logic [NR-1:0] exp_grant;
        logic [7:0]    exp_data;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic load(input int r, input int len, input logic [7:0] base, input bit rnd);
        for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            d = rnd ? 8'($urandom) : base + 8'(k);
            rq[r].push_back({(k == len - 1), d});
            mq[r].push_back({(k == len - 1), d});
        end
        plen[r].push_back(len);
    endtask

    // Frame-order model: round-robin over requesters holding pending frames, cap at ML bytes.
    task automatic plan();
        while (1) begin
            int pick;
            int len;
            pick = -1;
`ifdef ETH_TX_ARB_PRIO0_EN
            if (plen[0].size() > 0) pick = 0;
`endif
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (mptr + k) % NR;
                if (pick < 0 && plen[i].size() > 0) pick = i;
            end
            if (pick < 0) break;
`ifdef ETH_TX_ARB_PRIO0_EN
            if (pick != 0) mptr = (pick + 1) % NR;
`else
            mptr = (pick + 1) % NR;
`endif
            len = plen[pick].pop_front();
            for (int b = 0; b < len; b++) begin
                logic [8:0] x;
                x = mq[pick].pop_front();
                if (b < ML) exp_q.push_back({(b == len - 1) || (b == ML - 1), x[7:0]});
            end
            exp_frames++;
            if (len > ML) exp_trunc++;
        end
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < NR; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            bit v;
            v = (rq[i].size() > 0) && (at_start[i] || ($urandom_range(99) >= bubble_pct));
            bus.req_valid[i]      = v;
            bus.req_eof[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
            bus.req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
        end
        case (ready_mode)
            1:       bus.mac_ready = ($urandom_range(99) < ready_pct);
            2:       begin bus.mac_ready = phase; phase = ~phase; end
            default: bus.mac_ready = 1'b1;
        endcase
        #1;
        check("ready_only_to_grant", bus.req_ready & ~grant, 0);
        if (chk_mirror && busy) check("ready_mirror", bus.req_ready[1], bus.mac_ready);
        if (bus.mac_valid && bus.mac_ready) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL mac_extra_beat: got 0x%0h expected no beat", {bus.mac_eof, bus.mac_data});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("mac_beat", {bus.mac_eof, bus.mac_data}, e);
            end
        end
        if (trunc_pulse) begin
            trunc_seen++;
            trunc_cyc = cyc;
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i] && rq[i].size() > 0) begin
                logic [8:0] h;
                h = rq[i].pop_front();
                at_start[i] = h[8];
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((pending() != 0 || exp_q.size() != 0 || busy) && n < max_cyc);
        check("stream_drained", exp_q.size(), 0);
        check("inputs_consumed", pending(), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            mq[i].delete();
            plen[i].delete();
            at_start[i] = 1'b1;
        end
        exp_q.delete();
        mptr       = 0;
        exp_frames = 0;
        bus.req_valid = '0;
        bus.req_eof   = '0;
        bus.req_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.mac_ready = 1'b1;
        bubble_pct = 0; ready_mode = 0; ready_pct = 100;
        phase = 1'b0; chk_mirror = 1'b0;
        cyc = 0; first_acc = -1; last_acc = -1;
        trunc_seen = 0; trunc_cyc = -1; exp_trunc = 0;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_mac_valid", bus.mac_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_trunc", trunc_pulse, 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef ETH_TX_ARB_PRIO0_EN
        tbl[0] = '{4'b0100, 4'b0100, 8'hA2};
        tbl[1] = '{4'b1011, 4'b0001, 8'hA0};
        tbl[2] = '{4'b1011, 4'b0001, 8'hA0};
        tbl[3] = '{4'b0101, 4'b0001, 8'hA0};
        tbl[4] = '{4'b0011, 4'b0001, 8'hA0};
        tbl[5] = '{4'b1111, 4'b0001, 8'hA0};
        tbl[6] = '{4'b0001, 4'b0001, 8'hA0};
        tbl[7] = '{4'b1110, 4'b1000, 8'hA3};
        tbl[8] = '{4'b0110, 4'b0010, 8'hA1};
`else
        tbl[0] = '{4'b0100, 4'b0100, 8'hA2};
        tbl[1] = '{4'b1011, 4'b1000, 8'hA3};
        tbl[2] = '{4'b1011, 4'b0001, 8'hA0};
        tbl[3] = '{4'b0101, 4'b0100, 8'hA2};
        tbl[4] = '{4'b0011, 4'b0001, 8'hA0};
        tbl[5] = '{4'b1111, 4'b0010, 8'hA1};
        tbl[6] = '{4'b0001, 4'b0001, 8'hA0};
        tbl[7] = '{4'b1110, 4'b0010, 8'hA1};
        tbl[8] = '{4'b0110, 4'b0100, 8'hA2};
`endif
        // Single-byte frames offered by a mask of requesters; one beat per record.
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_eof   = '1;
        bus.mac_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            bus.req_valid = tbl[t].mask;
            @(negedge clk);
            #1;
            check($sformatf("tbl%0d_grant", t), grant, tbl[t].exp_grant);
            check($sformatf("tbl%0d_data", t), bus.mac_data, tbl[t].exp_data);
            check($sformatf("tbl%0d_eof", t), bus.mac_eof, 1);
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            check($sformatf("tbl%0d_release", t), grant, 0);
            check($sformatf("tbl%0d_frames", t), frame_cnt, t + 1);
        end
        do_reset();

        // Single 5-byte frame from requester 2.
        load(2, 5, 8'h11, 0);
        plan();
        first_acc = -1;
        begin
            int c0;
            c0 = cyc;
            tick();
            check("single_idle_grant", grant, 0);
            tick();
            check("single_grant", grant, 4'b0100);
            check("single_first_byte", bus.mac_data, 8'h11);
            run_until_idle(100);
            check("single_latency", first_acc, c0 + 1);
            check("single_span", last_acc - first_acc, 4);
            check("single_frames", frame_cnt, 1);
            check("single_grant_after", grant, 0);
        end

        // Three requesters at once, then a second batch continuing the rotation.
        load(0, 3, 8'h00, 0); load(1, 3, 8'h10, 0); load(3, 3, 8'h30, 0);
        plan();
        first_acc = -1;
        run_until_idle(200);
        check("batch1_span", last_acc - first_acc, 10);
        load(0, 3, 8'h08, 0); load(1, 3, 8'h18, 0); load(0, 3, 8'h0C, 0);
        plan();
        first_acc = -1;
        run_until_idle(200);
        check("batch2_span", last_acc - first_acc, 10);
        check("batch_frames", frame_cnt, 16'(exp_frames));

        // Backpressure: mac_ready alternates 1,0,1,0 from the first PASS cycle.
        load(1, 4, 8'h51, 0);
        plan();
        ready_mode = 2; phase = 1'b0; chk_mirror = 1'b1; first_acc = -1;
        run_until_idle(100);
        check("bp_span", last_acc - first_acc, 6);
        ready_mode = 0; chk_mirror = 1'b0;

        // Overlong frame is cut at ML bytes and the remainder drained.
        load(3, 20, 8'h00, 0);
        plan();
        trunc_seen = 0; first_acc = -1;
        run_until_idle(200);
        check("trunc_pulses", trunc_seen, 1);
        check("trunc_timing", trunc_cyc, last_acc + 1);
        check("trunc_frames", frame_cnt, 16'(exp_frames));
        check("trunc_idle", busy, 0);

        // Exactly ML bytes ends naturally.
        load(2, ML, 8'h60, 0);
        plan();
        trunc_seen = 0;
        run_until_idle(200);
        check("exact_no_trunc", trunc_seen, 0);
        check("exact_frames", frame_cnt, 16'(exp_frames));

        // Asynchronous reset in the middle of an 8-byte frame.
        load(1, 8, 8'h40, 0);
        plan();
        begin
            int k;
            k = 0;
            while (exp_q.size() > 5 && k < 50) begin
                tick();
                k++;
            end
        end
        check("midrst_progress", exp_q.size(), 5);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_mac_valid", bus.mac_valid, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_busy", busy, 0);
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        load(2, 3, 8'h20, 0); load(0, 3, 8'h70, 0); load(0, 3, 8'h78, 0);
        plan();
        tick();
        tick();
        check("postrst_first_grant", grant, 4'b0001);
        run_until_idle(200);
        check("postrst_frames", frame_cnt, 16'(exp_frames));

        // Randomized frames, bubbles and backpressure against the frame-order model.
        for (int r = 0; r < 3; r++) begin
            int tb0;
            bubble_pct = 30; ready_mode = 1; ready_pct = 60;
            exp_trunc = 0;
            tb0 = trunc_seen;
            for (int j = 0; j < 10; j++) load($urandom_range(NR - 1), $urandom_range(22, 1), 8'h00, 1);
            plan();
            run_until_idle(5000);
            check($sformatf("rand%0d_frames", r), frame_cnt, 16'(exp_frames));
            check($sformatf("rand%0d_truncs", r), trunc_seen - tb0, exp_trunc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
